// File: rtl/gamma_pkg.sv
// Shared constants, swap FSM state type and the bypass bit-replication helper
// for the gamma correction pipeline.
package gamma_pkg;

  localparam logic [1:0] CH_RED   = 2'd0;
  localparam logic [1:0] CH_GREEN = 2'd1;
  localparam logic [1:0] CH_BLUE  = 2'd2;
  localparam logic [1:0] CH_RSVD  = 2'd3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } swap_state_e;

  // Left-justify an in_w-bit code into out_w bits, refilling the low bits by
  // cycling through the code from its MSB downward.
  function automatic logic [31:0] bit_replicate(input logic [31:0] code,
                                                input int in_w,
                                                input int out_w);
    logic [31:0] res;
    res = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < out_w) begin
        res = res | (((code >> (in_w - 1 - (i % in_w))) & 32'd1) << (out_w - 1 - i));
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/gamma_lut_bank.sv
// One channel of double-banked gamma table: 2 x 2^IN_W entries, one write
// port and one registered read port.
module gamma_lut_bank #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic             wr_bank,
  input  logic [IN_W-1:0]  wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             rd_bank,
  input  logic [IN_W-1:0]  rd_addr,
  output logic [OUT_W-1:0] rd_data
);

  logic [OUT_W-1:0] mem [2**(IN_W+1)];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[{wr_bank, wr_addr}] <= wr_data;
    end
    rd_data <= mem[{rd_bank, rd_addr}];
  end

endmodule

// File: rtl/gamma_lut_pipe.sv
// Two-stage RGB gamma correction with host-loaded shadow tables and a bank
// swap that only lands on a frame boundary.
module gamma_lut_pipe
  import gamma_pkg::*;
#(
  parameter int R_W   = 7,
  parameter int G_W   = 7,
  parameter int B_W   = 6,
  parameter int OUT_W = 8,
  localparam int A_W  = (R_W > G_W) ? ((R_W > B_W) ? R_W : B_W)
                                    : ((G_W > B_W) ? G_W : B_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             frame_start,
  input  logic [R_W-1:0]   red_in,
  input  logic [G_W-1:0]   green_in,
  input  logic [B_W-1:0]   blue_in,
  input  logic             bypass,
  input  logic             wr_en,
  input  logic [1:0]       wr_chan,
  input  logic [A_W-1:0]   wr_addr,
  input  logic [OUT_W-1:0] wr_data,
  input  logic             swap_req,
  output logic             swap_pending,
  output logic             active_bank,
  output logic             out_valid,
  output logic [OUT_W-1:0] red_out,
  output logic [OUT_W-1:0] green_out,
  output logic [OUT_W-1:0] blue_out
);

  swap_state_e      state;
  logic             bank_sel;
  logic             wr_open;
  logic             we_red, we_green, we_blue;

  logic             vld_p1, byp_p1, bank_p1;
  logic [R_W-1:0]   red_p1;
  logic [G_W-1:0]   green_p1;
  logic [B_W-1:0]   blue_p1;

  logic             vld_p2, byp_p2;
  logic [OUT_W-1:0] red_rep_p2, green_rep_p2, blue_rep_p2;
  logic [OUT_W-1:0] red_lut_p2, green_lut_p2, blue_lut_p2;

  // The pixel carrying the applying frame_start already sees the new bank.
  always_comb begin
    bank_sel = active_bank;
    if (state == ST_PENDING && frame_start) begin
      bank_sel = ~active_bank;
    end
  end

  // Host writes are refused while a swap is armed, since the shadow bank is
  // about to go live.
  assign wr_open = wr_en && (state == ST_IDLE);

  always_comb begin
    we_red   = 1'b0;
    we_green = 1'b0;
    we_blue  = 1'b0;
    if (wr_open) begin
      case (wr_chan)
        CH_RED:   we_red   = ((wr_addr >> R_W) == '0);
        CH_GREEN: we_green = ((wr_addr >> G_W) == '0);
        CH_BLUE:  we_blue  = ((wr_addr >> B_W) == '0);
        CH_RSVD:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      swap_pending <= 1'b0;
      active_bank  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (swap_req) begin
            state        <= ST_PENDING;
            swap_pending <= 1'b1;
          end
        end
        ST_PENDING: begin
          if (frame_start) begin
            state        <= ST_IDLE;
            swap_pending <= 1'b0;
            active_bank  <= ~active_bank;
          end
        end
        default: begin
          state        <= ST_IDLE;
          swap_pending <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture codes, qualifier, bypass and bank select
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
    end
    red_p1   <= red_in;
    green_p1 <= green_in;
    blue_p1  <= blue_in;
    byp_p1   <= bypass;
    bank_p1  <= bank_sel;
  end

  // Stage 2: table read (inside the banks) and bypass replication
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
    end
    byp_p2       <= byp_p1;
    red_rep_p2   <= OUT_W'(bit_replicate(32'(red_p1), R_W, OUT_W));
    green_rep_p2 <= OUT_W'(bit_replicate(32'(green_p1), G_W, OUT_W));
    blue_rep_p2  <= OUT_W'(bit_replicate(32'(blue_p1), B_W, OUT_W));
  end

  gamma_lut_bank #(.IN_W(R_W), .OUT_W(OUT_W)) u_red (
    .clk(clk), .wr_en(we_red), .wr_bank(~active_bank),
    .wr_addr(wr_addr[R_W-1:0]), .wr_data(wr_data),
    .rd_bank(bank_p1), .rd_addr(red_p1), .rd_data(red_lut_p2)
  );

  gamma_lut_bank #(.IN_W(G_W), .OUT_W(OUT_W)) u_green (
    .clk(clk), .wr_en(we_green), .wr_bank(~active_bank),
    .wr_addr(wr_addr[G_W-1:0]), .wr_data(wr_data),
    .rd_bank(bank_p1), .rd_addr(green_p1), .rd_data(green_lut_p2)
  );

  gamma_lut_bank #(.IN_W(B_W), .OUT_W(OUT_W)) u_blue (
    .clk(clk), .wr_en(we_blue), .wr_bank(~active_bank),
    .wr_addr(wr_addr[B_W-1:0]), .wr_data(wr_data),
    .rd_bank(bank_p1), .rd_addr(blue_p1), .rd_data(blue_lut_p2)
  );

  // Data registers carry no reset; gating by the qualifier keeps outputs at
  // zero out of reset and between pixels.
  always_comb begin
    out_valid = vld_p2;
    red_out   = '0;
    green_out = '0;
    blue_out  = '0;
    if (vld_p2) begin
      red_out   = byp_p2 ? red_rep_p2   : red_lut_p2;
      green_out = byp_p2 ? green_rep_p2 : green_lut_p2;
      blue_out  = byp_p2 ? blue_rep_p2  : blue_lut_p2;
    end
  end

endmodule

// File: tb/tb_gamma_lut_pipe.sv
// Scoreboard bench for gamma_lut_pipe: a table/bank model predicts each pixel,
// a negedge monitor pops and compares when out_valid appears.
module tb_gamma_lut_pipe;

  localparam int R_W = 7, G_W = 7, B_W = 6, OUT_W = 8, A_W = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset, in_valid, frame_start, bypass, wr_en, swap_req;
  logic [R_W-1:0]   red_in;
  logic [G_W-1:0]   green_in;
  logic [B_W-1:0]   blue_in;
  logic [1:0]       wr_chan;
  logic [A_W-1:0]   wr_addr;
  logic [OUT_W-1:0] wr_data;
  logic             swap_pending, active_bank, out_valid;
  logic [OUT_W-1:0] red_out, green_out, blue_out;

  gamma_lut_pipe #(.R_W(R_W), .G_W(G_W), .B_W(B_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .frame_start(frame_start),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in), .bypass(bypass),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_addr(wr_addr), .wr_data(wr_data),
    .swap_req(swap_req), .swap_pending(swap_pending), .active_bank(active_bank),
    .out_valid(out_valid), .red_out(red_out), .green_out(green_out),
    .blue_out(blue_out)
  );

  typedef struct {
    int r;
    int g;
    int b;
    int due;
  } exp_t;

  exp_t sb[$];
  int   tab [2][3][1024];
  int   m_bank = 0;
  int   m_pend = 0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc++;

  // Bypass reference: shift left, then OR in the top bits again (valid for 4..8 bit codes).
  function automatic int rep(int v, int w);
    return ((v << (8 - w)) | (v >> (2 * w - 8))) & 255;
  endfunction

  // Predict the effect of the coming clock edge, then advance one cycle.
  task automatic step();
    exp_t e;
    int sel, ch, lim;
    if (reset) begin
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      m_bank = 0;
      m_pend = 0;
    end else begin
      sel = (m_pend != 0 && frame_start) ? 1 - m_bank : m_bank;
      if (in_valid) begin
        if (bypass) begin
          e.r = rep(int'(red_in), R_W);
          e.g = rep(int'(green_in), G_W);
          e.b = rep(int'(blue_in), B_W);
        end else begin
          e.r = tab[sel][0][red_in];
          e.g = tab[sel][1][green_in];
          e.b = tab[sel][2][blue_in];
        end
        e.due = cyc + 2;
        sb.push_back(e);
      end
      if (wr_en && m_pend == 0 && wr_chan != 2'd3) begin
        ch  = int'(wr_chan);
        lim = (ch == 0) ? (1 << R_W) : (ch == 1) ? (1 << G_W) : (1 << B_W);
        if (int'(wr_addr) < lim) tab[1 - m_bank][ch][wr_addr] = int'(wr_data);
      end
      if (m_pend == 0 && swap_req) m_pend = 1;
      else if (m_pend != 0 && frame_start) begin
        m_bank = 1 - m_bank;
        m_pend = 0;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; frame_start = 1'b0; wr_en = 1'b0; swap_req = 1'b0;
  endtask

  task automatic host_write(int ch, int a, int d);
    wr_en = 1'b1; wr_chan = 2'(ch); wr_addr = 7'(a); wr_data = 8'(d);
    step();
  endtask

  task automatic pixel(int r, int g, int b, bit fs);
    in_valid = 1'b1; frame_start = fs;
    red_in = 7'(r); green_in = 7'(g); blue_in = 6'(b);
    step();
  endtask

  // Scoreboard monitor; -1 marks a table entry never written (value not checked).
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected cyc=%0d out=%0d/%0d/%0d", cyc, red_out, green_out, blue_out);
      end else begin
        e = sb.pop_front();
        if ((e.r >= 0 && red_out !== 8'(e.r)) || (e.g >= 0 && green_out !== 8'(e.g)) ||
            (e.b >= 0 && blue_out !== 8'(e.b)) || e.due != cyc) begin
          failures++;
          $display("FAIL sb_pixel cyc=%0d actual=%0d/%0d/%0d expected=%0d/%0d/%0d due=%0d",
                   cyc, red_out, green_out, blue_out, e.r, e.g, e.b, e.due);
        end
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      checks++;
      failures++;
      e = sb.pop_front();
      $display("FAIL sb_missing cyc=%0d out_valid=%b expected_due=%0d", cyc, out_valid, e.due);
    end
  end

  task automatic test_reset();
    reset = 1'b1; bypass = 1'b1;
    pixel(5, 5, 5, 1'b1);
    step();
    checks++;
    if (out_valid !== 1'b0 || red_out !== 8'd0 || green_out !== 8'd0 || blue_out !== 8'd0) begin
      failures++;
      $display("FAIL reset_outputs actual=%b/%0d/%0d/%0d expected=0/0/0/0",
               out_valid, red_out, green_out, blue_out);
    end
    checks++;
    if (swap_pending !== 1'b0 || active_bank !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl actual=%b/%b expected=0/0", swap_pending, active_bank);
    end
    reset = 1'b0;
    pixel(127, 64, 63, 1'b0);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bypass_latency1 actual=%b expected=0", out_valid);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || red_out !== 8'd255 || green_out !== 8'd129 || blue_out !== 8'd255) begin
      failures++;
      $display("FAIL bypass_value actual=%b/%0d/%0d/%0d expected=1/255/129/255",
               out_valid, red_out, green_out, blue_out);
    end
  endtask

  task automatic test_swap_basic();
    bypass = 1'b0;
    for (int i = 0; i < 128; i++) host_write(0, i, 255 - 2 * i);
    for (int i = 0; i < 128; i++) host_write(1, i, 255 - 2 * i);
    for (int i = 0; i < 64; i++) host_write(2, i, 255 - 4 * i);
    swap_req = 1'b1;
    step();
    checks++;
    if (swap_pending !== 1'b1 || active_bank !== 1'b0) begin
      failures++;
      $display("FAIL swap_armed actual=%b/%b expected=1/0", swap_pending, active_bank);
    end
    pixel(0, 0, 0, 1'b0);
    pixel(0, 0, 0, 1'b1);
    checks++;
    if (active_bank !== 1'b1 || swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL swap_applied actual=%b/%b expected=1/0", active_bank, swap_pending);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || red_out !== 8'd255 || green_out !== 8'd255 || blue_out !== 8'd255) begin
      failures++;
      $display("FAIL swap_first_pixel actual=%b/%0d/%0d/%0d expected=1/255/255/255",
               out_valid, red_out, green_out, blue_out);
    end
  endtask

  task automatic test_pending_write();
    host_write(0, 5, 8'h11);
    host_write(2, 0, 8'h22);
    host_write(3, 0, 8'h77);
    host_write(2, 64, 8'h99);
    swap_req = 1'b1;
    step();
    host_write(0, 5, 8'h55);
    pixel(5, 0, 0, 1'b1);
    step();
    checks++;
    if (active_bank !== 1'b0 || red_out !== 8'h11 || blue_out !== 8'h22) begin
      failures++;
      $display("FAIL pending_write_drop actual=%b/%0h/%0h expected=0/11/22",
               active_bank, red_out, blue_out);
    end
  endtask

  task automatic test_swap_same_cycle();
    in_valid = 1'b1; frame_start = 1'b1; swap_req = 1'b1;
    red_in = '0; green_in = '0; blue_in = '0;
    step();
    checks++;
    if (active_bank !== 1'b0 || swap_pending !== 1'b1) begin
      failures++;
      $display("FAIL same_cycle_arm actual=%b/%b expected=0/1", active_bank, swap_pending);
    end
    swap_req = 1'b1;
    step();
    checks++;
    if (active_bank !== 1'b0 || swap_pending !== 1'b1) begin
      failures++;
      $display("FAIL double_req actual=%b/%b expected=0/1", active_bank, swap_pending);
    end
    pixel(0, 0, 0, 1'b1);
    checks++;
    if (active_bank !== 1'b1 || swap_pending !== 1'b0) begin
      failures++;
      $display("FAIL deferred_flip actual=%b/%b expected=1/0", active_bank, swap_pending);
    end
    pixel(0, 0, 0, 1'b1);
    checks++;
    if (active_bank !== 1'b1) begin
      failures++;
      $display("FAIL single_flip actual=%b expected=1", active_bank);
    end
    step();
    checks++;
    if (red_out !== 8'd255 || blue_out !== 8'd255) begin
      failures++;
      $display("FAIL bank1_read actual=%0d/%0d expected=255/255", red_out, blue_out);
    end
  endtask

  task automatic test_random_stream();
    for (int n = 0; n < 1000; n++) begin
      if (n == 300) bypass = 1'b1;
      if (n == 650) bypass = 1'b0;
      pixel($urandom_range(127), $urandom_range(127), $urandom_range(63), (n % 97) == 0);
    end
    bypass = 1'b1;
    for (int n = 0; n < 20; n++) pixel($urandom_range(127), $urandom_range(127), $urandom_range(63), 1'b0);
    repeat (3) step();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL stream_drain actual=%0d expected=0", sb.size());
    end
  endtask

  task automatic test_reset_midflight();
    bypass = 1'b1;
    swap_req = 1'b1;
    step();
    pixel(10, 20, 30, 1'b0);
    pixel(40, 50, 60, 1'b0);
    reset = 1'b1;
    pixel(1, 2, 3, 1'b0);
    checks++;
    if (out_valid !== 1'b0 || swap_pending !== 1'b0 || active_bank !== 1'b0) begin
      failures++;
      $display("FAIL reset_midflight actual=%b/%b/%b expected=0/0/0",
               out_valid, swap_pending, active_bank);
    end
    reset = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_flush actual=%b expected=0", out_valid);
    end
    repeat (3) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    for (int b = 0; b < 2; b++)
      for (int c = 0; c < 3; c++)
        for (int a = 0; a < 1024; a++) tab[b][c][a] = -1;
    reset = 1'b1; in_valid = 1'b0; frame_start = 1'b0; bypass = 1'b1;
    wr_en = 1'b0; swap_req = 1'b0; wr_chan = '0; wr_addr = '0; wr_data = '0;
    red_in = '0; green_in = '0; blue_in = '0;
    test_reset();
    test_swap_basic();
    test_pending_write();
    test_swap_same_cycle();
    test_random_stream();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gamma_lut_pipe.md
Name: gamma_lut_pipe

Overview:
Pipelined, run-time programmable gamma correction for the RGB pixel stream ahead of the panel driver. Each of three channels has its own double-banked lookup table (active plus shadow), mapping an IN_W-bit code to an OUT_W-bit level. A host write port loads the shadow bank. A bank swap is armed by the host and takes effect only on a frame boundary, so a frame never mixes tables. A bypass mode passes bit-replicated input straight through.

Parameters:
R_W, 7, red input width (1..10)
G_W, 7, green input width (1..10)
B_W, 6, blue input width (1..10)
OUT_W, 8, output width per channel (>= each input width)
A_W, derived = max(R_W,G_W,B_W), host address width (localparam, not overridable)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  pixel qualifier
frame_start  in  1  one-cycle pulse, first pixel of frame (coincides with that pixel's in_valid)
red_in  in  R_W  red code
green_in  in  G_W  green code
blue_in  in  B_W  blue code
bypass  in  1  1 = pass-through, 0 = LUT
wr_en  in  1  host table write strobe
wr_chan  in  2  0=red 1=green 2=blue 3=reserved
wr_addr  in  A_W  table index
wr_data  in  OUT_W  table entry
swap_req  in  1  one-cycle pulse: arm bank swap
swap_pending  out  1  swap armed, not yet applied
active_bank  out  1  bank currently used for lookup
out_valid  out  1  output qualifier
red_out  out  OUT_W  corrected red
green_out  out  OUT_W  corrected green
blue_out  out  OUT_W  corrected blue

Behaviour:
- Single clock. All state is synchronous to clk. reset is synchronous and active-high.
- Reset values: out_valid=0, all *_out=0, active_bank=0, swap_pending=0, pipeline valids cleared. Table RAM contents are not reset and are undefined until written. Until tables are loaded, the host holds bypass=1.
- Latency: fixed 2 cycles, in_valid→out_valid. No backpressure. Every accepted pixel emerges.
- Stage 1 registers the codes, valid, bypass and the bank select. Stage 2 performs the synchronous RAM read and output register.
- Bank select is captured per pixel at stage 1. A pixel uses the bank that is active in the cycle it enters.
- Bypass: out = input left-justified, low bits filled by repeating the input MSBs. Example: 7-bit 127 → 255, 7-bit 64 → 129, 6-bit 63 → 255. Bypass is sampled per pixel and takes effect with 2-cycle latency.
- Host writes always target the shadow bank (~active_bank).
  - wr_chan=3 is ignored.
  - An address >= 2^(channel width) is ignored, e.g. blue addr 64 with B_W=6.
  - A write to the same channel/address in consecutive cycles: the last one wins.
- Swap FSM:
  - IDLE: swap_req → PENDING; swap_pending=1 on the next cycle.
  - PENDING: a cycle with frame_start=1 flips active_bank and returns to IDLE. The pixel carrying that frame_start uses the new bank.
  - PENDING: swap_req is ignored (no double flip).
  - PENDING: wr_en is dropped, because the shadow bank is about to become active.
- Simultaneous swap_req and frame_start while IDLE: arm only. The swap applies at the next frame_start.
- Reset mid-frame: in-flight pixels are discarded, out_valid=0 next cycle, and a pending swap is cancelled.
- frame_start without in_valid is still honoured for the swap.

Decomposition:
- Package gamma_pkg holds:
  - channel-select constants CH_RED, CH_GREEN, CH_BLUE, CH_RSVD
  - swap FSM state enum (ST_IDLE, ST_PENDING)
  - the bit-replication function used for bypass
- Sub-module gamma_lut_bank: one channel, parameters IN_W and OUT_W, holding 2×2^IN_W entries. It has a one-write, one-read synchronous port with 1-cycle read latency and is instantiated three times.
- The top level holds the input stage, swap FSM, write decode and output register.

Test Plan:
- Reset, bypass=1, R/G/B = 127/64/63 with in_valid → 2 cycles later out = 255/129/255, out_valid=1. During reset all outputs are 0.
- Load shadow bank 1 with inverse tables (red[i]=255-2i, etc.), then swap_req, then frame_start with red_in=0 → active_bank=1, red_out=255 after 2 cycles. The preceding pixel (red_in=0) still reads bank 0.
- Write during PENDING (red addr 5 ← 0x55) → dropped. Read back after swap ≠ 0x55. Writes with wr_chan=3 and blue addr 64 leave all tables unchanged.
- swap_req on the same cycle as frame_start → no flip. Flip occurs at the following frame_start. A second swap_req while pending produces a single flip only.
- Continuous in_valid stream of 1000 random pixels, toggling bypass mid-stream → every output matches the reference model with 2-cycle alignment and no dropped valids.
- Assert reset while swap_pending=1 and 2 pixels are in flight → next cycle out_valid=0, swap_pending=0, active_bank=0.
